// File: rtl/coeff_loader.sv
// Coefficient transmitter and sample gate for the 4-tap FIR filter.
// Resets the filter, streams four taps from a local bank, then flushes it.
module coeff_loader #(
  parameter int RST_CYCLES   = 2,
  parameter int FLUSH_CYCLES = 4,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       start,
  input  logic [7:0] x_in,
  output logic [7:0] x_out,
  output logic       filt_rst,
  output logic [7:0] coef_out,
  output logic       coef_valid,
  output logic       busy,
  output logic       done,
  output logic       wr_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RST,
    S_LOAD,
    S_FLUSH
  } state_e;

  localparam logic [3:0] RST_LAST   = 4'(RST_CYCLES - 1);
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][7:0] bank_q, bank_d;
  logic            wr_err_q, wr_err_d;
  logic            auto_q, auto_d;
  logic [7:0]      x_out_q, x_out_d;
  logic            filt_rst_q, filt_rst_d;
  logic [7:0]      coef_out_q, coef_out_d;
  logic            coef_valid_q, coef_valid_d;
  logic            done_q, done_d;
  logic            accept;

  assign busy       = (state_q != S_IDLE);
  assign rd_data    = bank_q[rd_addr];
  assign x_out      = x_out_q;
  assign filt_rst   = filt_rst_q;
  assign coef_out   = coef_out_q;
  assign coef_valid = coef_valid_q;
  assign done       = done_q;
  assign wr_err     = wr_err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    bank_d   = bank_q;
    wr_err_d = wr_err_q;
    auto_d   = 1'b0;
    accept   = (state_q == S_IDLE) && (start || auto_q);

    if (wr_en) begin
      if (busy) wr_err_d = 1'b1;
      else      bank_d[wr_addr] = wr_data;
    end
    if (accept) wr_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RST;
          cnt_d   = RST_LAST;
        end
      end
      S_RST: begin
        if (cnt_q == 4'd0) begin
          state_d = S_LOAD;
          idx_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_LOAD: begin
        if (idx_q == 2'd3) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LAST;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    filt_rst_d   = (state_d == S_RST);
    coef_valid_d = (state_d == S_LOAD);
    coef_out_d   = (state_d == S_LOAD) ? bank_d[idx_d] : 8'd0;
    x_out_d      = (state_d == S_IDLE) ? x_in : 8'd0;
    done_d       = (state_d == S_FLUSH) && (cnt_d == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      idx_q        <= 2'd0;
      bank_q       <= '0;
      wr_err_q     <= 1'b0;
      auto_q       <= AUTO_START;
      x_out_q      <= 8'd0;
      filt_rst_q   <= 1'b0;
      coef_out_q   <= 8'd0;
      coef_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      bank_q       <= bank_d;
      wr_err_q     <= wr_err_d;
      auto_q       <= auto_d;
      x_out_q      <= x_out_d;
      filt_rst_q   <= filt_rst_d;
      coef_out_q   <= coef_out_d;
      coef_valid_q <= coef_valid_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_coeff_loader.sv
// Scoreboard bench for coeff_loader: taps are queued at start and
// checked by a monitor whenever coef_valid is seen.
module tb_coeff_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       start;
  logic [7:0] x_in = 8'd0;
  logic [7:0] x_out;
  logic       filt_rst;
  logic [7:0] coef_out;
  logic       coef_valid;
  logic       busy;
  logic       done;
  logic       wr_err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  coeff_loader #(
    .RST_CYCLES(2),
    .FLUSH_CYCLES(4),
    .AUTO_START(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .start(start),
    .x_in(x_in),
    .x_out(x_out),
    .filt_rst(filt_rst),
    .coef_out(coef_out),
    .coef_valid(coef_valid),
    .busy(busy),
    .done(done),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 x_in = x_in + 8'd1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (coef_valid) begin
      if (exp_q.size() == 0) begin
        chk("coef_unexpected", {24'd0, coef_out}, 32'hFFFF_FFFF);
      end else begin
        chk("coef_out", {24'd0, coef_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  task automatic chk_bank(input logic [7:0] v0, input logic [7:0] v1,
                          input logic [7:0] v2, input logic [7:0] v3);
    logic [7:0] v [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1 chk("rd_data", {24'd0, rd_data}, {24'd0, v[i]});
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Called at posedge+1 with the request already set up; the next edge
  // is the accepting edge. Walks the whole 10-cycle sequence.
  task automatic run_seq(input bit busy_wr);
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("filt_rst", {31'd0, filt_rst}, {31'd0, k <= 2});
      chk("coef_valid", {31'd0, coef_valid}, {31'd0, (k >= 3) && (k <= 6)});
      chk("done", {31'd0, done}, {31'd0, k == 10});
      chk("busy", {31'd0, busy}, 32'd1);
      chk("x_out_gated", {24'd0, x_out}, 32'd0);
      if (k == 1) chk("wr_err_clr", {31'd0, wr_err}, 32'd0);
      if (busy_wr && k == 4) begin
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hFF; start = 1'b1;
      end
      if (busy_wr && k == 5) begin
        wr_en = 1'b0; start = 1'b0;
        chk("wr_err_set", {31'd0, wr_err}, 32'd1);
      end
    end
    @(negedge clk);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("done_end", {31'd0, done}, 32'd0);
    chk("x_out_resume", {24'd0, x_out}, {24'd0, x_in - 8'd1});
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_en = 1'b0;
    wr_addr = 2'd0; wr_data = 8'd0; rd_addr = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_filt_rst", {31'd0, filt_rst}, 32'd0);
    chk("rst_coef_valid", {31'd0, coef_valid}, 32'd0);
    chk("rst_coef_out", {24'd0, coef_out}, 32'd0);
    chk("rst_x_out", {24'd0, x_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_err", {31'd0, wr_err}, 32'd0);
    chk_bank(8'h00, 8'h00, 8'h00, 8'h00);

    // Auto-start after reset release with an all-zero bank.
    @(posedge clk); #1;
    push4(8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    run_seq(1'b0);

    // Load taps in IDLE and read them back.
    wr(2'd0, 8'h11);
    wr(2'd1, 8'h22);
    wr(2'd2, 8'h33);
    wr(2'd3, 8'h44);
    chk_bank(8'h11, 8'h22, 8'h33, 8'h44);
    @(posedge clk); #1;

    // Start, then a write and a start while busy: both dropped.
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    start = 1'b1;
    run_seq(1'b1);
    chk("wr_err_sticky", {31'd0, wr_err}, 32'd1);
    chk_bank(8'h11, 8'h22, 8'h33, 8'h44);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_x_out", {24'd0, x_out}, {24'd0, x_in - 8'd1});
    end
    @(posedge clk); #1;

    // Same-cycle write and start: new tap goes out first.
    push4(8'h5A, 8'h22, 8'h33, 8'h44);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h5A; start = 1'b1;
    run_seq(1'b0);
    chk_bank(8'h5A, 8'h22, 8'h33, 8'h44);
    @(posedge clk); #1;

    // Reset during LOAD at idx=2.
    push4(8'h5A, 8'h22, 8'h33, 8'h44);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_filt_rst", {31'd0, filt_rst}, 32'd0);
    chk("abort_coef_valid", {31'd0, coef_valid}, 32'd0);
    chk("abort_coef_out", {24'd0, coef_out}, 32'd0);
    chk("abort_x_out", {24'd0, x_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk_bank(8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clk); #1;
    push4(8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    run_seq(1'b0);

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coeff_loader.md
# coeff_loader

Coefficient transmitter and sample gate for the 4-tap FIR filter. Host logic writes four 8-bit taps into a local bank. On request, the block resets the filter, drives the taps h[0]..h[3] onto the filter's coefficient bus in the four cycles its load window is open, and then flushes the filter's delay line with zero samples. It sits between the host/config logic and the filter and is the sending end of the filter's post-reset coefficient-load interface.

## Interface
Parameters:
- RST_CYCLES, 2: cycles filt_rst is held high per sequence (legal 1..15).
- FLUSH_CYCLES, 4: zero-sample cycles after the load (legal 1..15).
- AUTO_START, 1: 1 = run one sequence automatically after reset release.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  bank write strobe.
- wr_addr  in  2  bank index for the write.
- wr_data  in  8  tap value for the write.
- rd_addr  in  2  readback index.
- rd_data  out  8  bank[rd_addr]; combinational.
- start  in  1  request a load sequence; sampled each cycle.
- x_in  in  8  upstream sample stream.
- x_out  out  8  sample to filter; registered.
- filt_rst  out  1  filter reset, active-high; registered.
- coef_out  out  8  coefficient bus to filter; registered.
- coef_valid  out  1  high while coef_out carries a tap.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a sequence.
- wr_err  out  1  sticky flag: a write was attempted while busy.

## Operation
- Bank: 4×8 registers.
  - wr_en with busy=0 writes bank[wr_addr]<=wr_data.
  - wr_en with busy=1: the write is dropped and wr_err is set.
  - wr_err clears on reset or when a start is accepted.
- States and transitions:
  - IDLE: start=1 is accepted; go to RST next cycle.
  - RST: hold RST_CYCLES cycles, then go to LOAD.
  - LOAD: exactly 4 cycles with idx=0..3, then go to FLUSH.
  - FLUSH: hold FLUSH_CYCLES cycles, then go to IDLE.
- Outputs per state:
  - filt_rst=1 only in RST.
  - coef_valid=1 and coef_out=bank[idx] only in LOAD; otherwise coef_out=0.
  - x_out=0 in RST, LOAD and FLUSH.
  - In IDLE, x_out = x_in from the previous cycle.
  - done=1 in the last FLUSH cycle only.
- start is ignored when not in IDLE; this does not set an error.
- A write and an accepted start in the same cycle: the write is performed, and its new value is transmitted.
- Writes are blocked during a sequence, so the transmitted taps always equal the bank contents at sequence start plus any same-cycle write.
- AUTO_START=1: the first cycle after rst_n is released behaves as if start=1 in IDLE.
- Arithmetic: no arithmetic on data. Internal counters are 4 bits for RST/FLUSH and 2 bits for idx; no wrap other than idx 3→FLUSH.

## Timing
- Reset (rst_n=0 at an edge):
  - Next cycle: state=IDLE and bank all 0.
  - All registered outputs are 0: x_out, filt_rst, coef_out, coef_valid, busy, done, wr_err.
  - Reset takes priority over everything, including mid-sequence. A sequence aborted by reset is not resumed except via AUTO_START.
- start accepted at edge N (state IDLE):
  - Edges N+1..N+R: filt_rst=1 (R=RST_CYCLES).
  - Edges N+R+1..N+R+4: coef_valid=1, coef_out=h0,h1,h2,h3.
  - Edges N+R+5..N+R+4+F: x_out=0 (F=FLUSH_CYCLES); done=1 at N+R+4+F.
  - Edge N+R+5+F: IDLE, busy=0, x_out resumes.
- busy=1 from N+1 through N+R+4+F inclusive.
- Total sequence length is R+4+F cycles; defaults give 10.
- A start may be accepted in the first IDLE cycle after done. Back-to-back sequences have exactly one IDLE cycle between them.
- x_out latency in IDLE: 1 cycle.

## Test plan
- Reset then defaults (AUTO_START=1), bank 0 → after rst_n rises: filt_rst high for 2 cycles, then coef_out=00,00,00,00 with coef_valid, 4 zero samples, done pulse on cycle 10, busy low after.
- Write bank = {0x11,0x22,0x33,0x44} in IDLE, pulse start → coef_out sequence 11,22,33,44 on cycles 3..6 after start; rd_data reads back each value.
- During busy, write addr 1=0xFF and pulse start again → wr_err=1, bank[1] unchanged, no second sequence. Next accepted start clears wr_err.
- Write addr 0=0x5A in the same cycle as start → first transmitted tap is 0x5A.
- Drive x_in ramp 1,2,3… → x_out=0 throughout RST/LOAD/FLUSH, then follows x_in with 1-cycle latency in IDLE.
- Assert rst_n=0 during LOAD at idx=2 → next cycle all outputs 0, bank 0. With AUTO_START=1, a fresh sequence starts after release.
